// File: rtl/if_rf_reg.sv
// IF->RF pipeline register with flush, downstream stall and load-use bubble insertion.
// Optional macro HAZARD_DETECT_EN enables load-use hazard detection and the bubble counter.
module if_rf_reg #(
  parameter int BCNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         validIn,
  input  logic [12:0]  ctrlIn,
  input  logic [4:0]   RnIn,
  input  logic [4:0]   RmIn,
  input  logic [4:0]   RdIn,
  input  logic [90:0]  fieldsIn,
  input  logic [63:0]  PCIn,
  input  logic         flush,
  input  logic         stallDown,
  output logic         validOut,
  output logic [12:0]  ctrlOut,
  output logic [4:0]   RnOut,
  output logic [4:0]   RmOut,
  output logic [4:0]   RdOut,
  output logic [90:0]  fieldsOut,
  output logic [63:0]  PCOut,
  output logic         holdIF,
  output logic [15:0]  bubbleCount
);

  localparam int         CTRL_REG2LOC  = 12;
  localparam int         CTRL_REGWRITE = 11;
  localparam int         CTRL_LOAD     = 2;
  localparam logic [4:0] XZR           = 5'd31;

  logic              r_vld_p1;
  logic [12:0]       r_ctrl_p1;
  logic [4:0]        r_rn_p1;
  logic [4:0]        r_rm_p1;
  logic [4:0]        r_rd_p1;
  logic [90:0]       r_fields_p1;
  logic [63:0]       r_pc_p1;
  logic [BCNT_W-1:0] r_bcnt;
  logic              w_haz;
  logic [15:0]       w_bcnt_ext;

  function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

`ifdef HAZARD_DETECT_EN
  logic [4:0] w_src2;
  assign w_src2 = ctrlIn[CTRL_REG2LOC] ? RmIn : RdIn;
  // The RF instruction is a load writing a real register that the IF instruction reads.
  assign w_haz  = validIn & r_vld_p1 & r_ctrl_p1[CTRL_LOAD] & r_ctrl_p1[CTRL_REGWRITE]
                & (r_rd_p1 != XZR) & ((RnIn == r_rd_p1) | (w_src2 == r_rd_p1));
`else
  assign w_haz  = 1'b0;
`endif

  assign holdIF = ~reset & (stallDown | (w_haz & ~flush));

  // Stage p1: RF-stage copy of the IF instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_ctrl_p1   <= '0;
      r_rn_p1     <= '0;
      r_rm_p1     <= '0;
      r_rd_p1     <= '0;
      r_fields_p1 <= '0;
      r_pc_p1     <= '0;
      r_bcnt      <= '0;
    end else if (flush) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
    end else if (stallDown) begin
      r_vld_p1  <= r_vld_p1;
    end else if (w_haz) begin
      // Bubble: the IF instruction stays frozen upstream and loads next edge.
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
      r_bcnt    <= sat_inc(r_bcnt);
    end else begin
      r_vld_p1    <= validIn;
      r_ctrl_p1   <= validIn ? ctrlIn : '0;
      r_rn_p1     <= RnIn;
      r_rm_p1     <= RmIn;
      r_rd_p1     <= RdIn;
      r_fields_p1 <= fieldsIn;
      r_pc_p1     <= PCIn;
    end
  end

  always_comb begin
    w_bcnt_ext               = '0;
    w_bcnt_ext[BCNT_W-1:0]   = r_bcnt;
  end

  assign validOut    = r_vld_p1;
  assign ctrlOut     = r_ctrl_p1;
  assign RnOut       = r_rn_p1;
  assign RmOut       = r_rm_p1;
  assign RdOut       = r_rd_p1;
  assign fieldsOut   = r_fields_p1;
  assign PCOut       = r_pc_p1;
  assign bubbleCount = w_bcnt_ext;

endmodule

// File: tb/tb_if_rf_reg.sv
// Bench for if_rf_reg: stimulus table plus scoreboard of expected RF-stage state.
module tb_if_rf_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, validIn, flush, stallDown;
  logic [12:0]  ctrlIn;
  logic [4:0]   RnIn, RmIn, RdIn;
  logic [90:0]  fieldsIn;
  logic [63:0]  PCIn;
  logic         validOut, holdIF;
  logic [12:0]  ctrlOut;
  logic [4:0]   RnOut, RmOut, RdOut;
  logic [90:0]  fieldsOut;
  logic [63:0]  PCOut;
  logic [15:0]  bubbleCount;

  // Narrow counter so saturation is reachable in a short run.
  if_rf_reg #(.BCNT_W(4)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .ctrlIn(ctrlIn),
    .RnIn(RnIn), .RmIn(RmIn), .RdIn(RdIn), .fieldsIn(fieldsIn), .PCIn(PCIn),
    .flush(flush), .stallDown(stallDown), .validOut(validOut), .ctrlOut(ctrlOut),
    .RnOut(RnOut), .RmOut(RmOut), .RdOut(RdOut), .fieldsOut(fieldsOut),
    .PCOut(PCOut), .holdIF(holdIF), .bubbleCount(bubbleCount)
  );

`ifdef HAZARD_DETECT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [15:0] BMAX = 16'd15;

  localparam logic [12:0] LD   = 13'h0944;
  localparam logic [12:0] ADD  = 13'h1800;
  localparam logic [12:0] STR  = 13'h0440;
  localparam logic [12:0] STR1 = 13'h1440;

  typedef struct {
    logic rst, vin;
    logic [12:0] ctrl;
    logic [4:0] rn, rm, rd;
    logic fl, st;
    logic chk, hen, hdis, ven, vdis;
  } vec_t;

  typedef struct {
    logic v;
    logic [12:0] c;
    logic [4:0] rn, rm, rd;
    logic [90:0] f;
    logic [63:0] pc;
    logic [15:0] bc;
    logic dc, chk, hv;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic        m_v, m_dc;
  logic [12:0] m_c;
  logic [4:0]  m_rn, m_rm, m_rd;
  logic [90:0] m_f;
  logic [63:0] m_pc;
  logic [15:0] m_bc;

  function automatic vec_t mk(logic rst, logic vin, logic [12:0] c, logic [4:0] rn,
                              logic [4:0] rm, logic [4:0] rd, logic fl, logic st,
                              logic chk, logic hen, logic hdis, logic ven, logic vdis);
    vec_t v;
    v.rst = rst; v.vin = vin; v.ctrl = c; v.rn = rn; v.rm = rm; v.rd = rd;
    v.fl = fl; v.st = st; v.chk = chk; v.hen = hen; v.hdis = hdis;
    v.ven = ven; v.vdis = vdis;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("validOut", 128'(validOut), 128'(e.v));
      check("ctrlOut", 128'(ctrlOut), 128'(e.c));
      check("bubbleCount", 128'(bubbleCount), 128'(e.bc));
      if (!e.dc) begin
        check("RnOut", 128'(RnOut), 128'(e.rn));
        check("RmOut", 128'(RmOut), 128'(e.rm));
        check("RdOut", 128'(RdOut), 128'(e.rd));
        check("fieldsOut", 128'(fieldsOut), 128'(e.f));
        check("PCOut", 128'(PCOut), 128'(e.pc));
      end
      if (e.chk) check("validOut_table", 128'(validOut), 128'(e.hv));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with results compared.
  task automatic apply(input vec_t v);
    logic [63:0] pc;
    logic [4:0]  s2;
    logic        haz, hold;
    exp_t        e;
    pc = {32'hC0DE0000 | 32'(cyc), 32'(cyc * 4)};
    reset = v.rst; validIn = v.vin; ctrlIn = v.ctrl;
    RnIn = v.rn; RmIn = v.rm; RdIn = v.rd;
    fieldsIn = {pc[26:0], pc}; PCIn = pc;
    flush = v.fl; stallDown = v.st;
    #1;
    s2   = v.ctrl[12] ? v.rm : v.rd;
    haz  = EN && v.vin && m_v && m_c[2] && m_c[11] && (m_rd != 5'd31)
           && ((v.rn == m_rd) || (s2 == m_rd));
    hold = !v.rst && (v.st || (haz && !v.fl));
    check("holdIF", 128'(holdIF), 128'(hold));
    if (v.chk) check("holdIF_table", 128'(holdIF), 128'(EN ? v.hen : v.hdis));
    if (v.rst) begin
      m_v = 0; m_c = '0; m_rn = '0; m_rm = '0; m_rd = '0;
      m_f = '0; m_pc = '0; m_bc = '0; m_dc = 0;
    end else if (v.fl) begin
      m_v = 0; m_c = '0; m_dc = 1;
    end else if (v.st) begin
      m_v = m_v;
    end else if (haz) begin
      m_v = 0; m_c = '0;
      if (m_bc != BMAX) m_bc = m_bc + 16'd1;
    end else begin
      m_v = v.vin; m_c = v.vin ? v.ctrl : 13'd0;
      m_rn = v.rn; m_rm = v.rm; m_rd = v.rd;
      m_f = {pc[26:0], pc}; m_pc = pc; m_dc = 0;
    end
    e.v = m_v; e.c = m_c; e.rn = m_rn; e.rm = m_rm; e.rd = m_rd;
    e.f = m_f; e.pc = m_pc; e.bc = m_bc; e.dc = m_dc;
    e.chk = v.chk; e.hv = EN ? v.ven : v.vdis;
    q.push_back(e);
    cyc++;
    @(negedge clk);
    drain();
  endtask

  initial begin
    reset = 1; validIn = 0; ctrlIn = '0; RnIn = '0; RmIn = '0; RdIn = '0;
    fieldsIn = '0; PCIn = '0; flush = 0; stallDown = 0;
    m_v = 0; m_c = '0; m_rn = '0; m_rm = '0; m_rd = '0;
    m_f = '0; m_pc = '0; m_bc = '0; m_dc = 0;

    //                rst vin ctrl  rn  rm  rd fl st  chk hen hdis ven vdis
    tbl.push_back(mk(1, 1, LD,    3,  3,  3, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ADD,   7,  8,  9, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, LD,    1,  2,  3, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, ADD,   3,  4,  6, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, ADD,   3,  4,  6, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, LD,    2,  0, 31, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, ADD,  31, 31,  1, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, LD,    1,  0,  5, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, STR,   9, 10,  5, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, STR,   9, 10,  5, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, LD,    1,  0,  7, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, STR1,  9,  5,  7, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, LD,    1,  0,  3, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, ADD,   3,  4,  6, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, LD,    1,  0,  3, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, ADD,   3,  4,  6, 1, 1,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, ADD,   8,  9, 10, 0, 0,  1, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, LD,  1,  2,  9, 0, 1,  1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, ADD,   1,  2,  3, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, LD,    1,  0,  4, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, ADD,   4,  4,  4, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, LD,    1,  0,  4, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, ADD,   4,  5,  6, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, ADD,   4,  5,  6, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, ADD,   4,  5,  6, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, LD,    1,  0,  2, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, ADD,   2,  3,  1, 0, 1,  1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, ADD,   2,  3,  1, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, ADD,   2,  3,  1, 0, 0,  1, 0, 0, 1, 1));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i]);
    check("bubbleCount_after_table", 128'(bubbleCount), 128'(EN ? 16'd1 : 16'd0));

    // Back-to-back load/hazard pairs drive the counter into saturation.
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 1, LD, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, 1, LD, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    end
    check("bubbleCount_saturated", 128'(bubbleCount), 128'(EN ? BMAX : 16'd0));

    apply(mk(1, 0, '0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    check("bubbleCount_reset", 128'(bubbleCount), 128'(16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
